// File: rtl/cam_pkg.sv
// ----------------------------------------------------------------------------
// cam_pkg : shared types and constants for the camera blue-window statistics.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cam_pkg;

  localparam int PIX_W   = 8;
  localparam int X_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } cam_state_t;

endpackage

`default_nettype wire

// File: rtl/cam_window_acc.sv
// ----------------------------------------------------------------------------
// cam_window_acc : in-window test plus blue sum (and optional peak) accumulator.
// Optional feature macro: CAM_BLUE_PEAK_EN (adds o_peak).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cam_window_acc import cam_pkg::*; #(
  parameter int X_W        = X_W_DEF,
  parameter int WIN_LOG2_W = 4,
  parameter int WIN_LOG2_H = 4,
  parameter int SUM_W      = PIX_W + WIN_LOG2_W + WIN_LOG2_H
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_pix_en,
  input  logic [X_W-1:0]   i_x,
  input  logic [X_W-1:0]   i_y,
  input  logic [X_W-1:0]   i_wx,
  input  logic [X_W-1:0]   i_wy,
  input  logic [PIX_W-1:0] i_pix,
  output logic [SUM_W-1:0] o_sum
`ifdef CAM_BLUE_PEAK_EN
  ,output logic [PIX_W-1:0] o_peak
`endif
);

  localparam logic [X_W:0] c_WIN_W = (X_W+1)'(2**WIN_LOG2_W);
  localparam logic [X_W:0] c_WIN_H = (X_W+1)'(2**WIN_LOG2_H);

  logic w_in_x;
  logic w_in_y;
  logic w_acc;
  logic [SUM_W-1:0] r_sum;

  // One extra bit so a window hanging past the last column never wraps.
  assign w_in_x = ({1'b0, i_x} >= {1'b0, i_wx}) && ({1'b0, i_x} < ({1'b0, i_wx} + c_WIN_W));
  assign w_in_y = ({1'b0, i_y} >= {1'b0, i_wy}) && ({1'b0, i_y} < ({1'b0, i_wy} + c_WIN_H));
  assign w_acc  = i_pix_en & w_in_x & w_in_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (w_acc) begin
      r_sum <= r_sum + SUM_W'(i_pix);
    end
  end

  assign o_sum = r_sum;

`ifdef CAM_BLUE_PEAK_EN
  logic [PIX_W-1:0] r_peak;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak <= '0;
    end else if (i_clear) begin
      r_peak <= '0;
    end else if (w_acc && (i_pix > r_peak)) begin
      r_peak <= i_pix;
    end
  end

  assign o_peak = r_peak;
`endif

endmodule

`default_nettype wire

// File: rtl/camera_blue_window_avg.sv
// ----------------------------------------------------------------------------
// camera_blue_window_avg : per-frame average of blue over a selectable window.
// Optional feature macro: CAM_BLUE_PEAK_EN (adds blue_peak output).
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module camera_blue_window_avg import cam_pkg::*; #(
  parameter int X_W        = X_W_DEF,
  parameter int WIN_LOG2_W = 4,
  parameter int WIN_LOG2_H = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_valid,
  input  logic             line_valid,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_blue,
  input  logic [X_W-1:0]   win_x,
  input  logic [X_W-1:0]   win_y,
  output logic [PIX_W-1:0] blue_avg,
  output logic             avg_valid
`ifdef CAM_BLUE_PEAK_EN
  ,output logic [PIX_W-1:0] blue_peak
`endif
);

  localparam int SUM_W = PIX_W + WIN_LOG2_W + WIN_LOG2_H;

  cam_state_t       r_state;
  logic             r_fv_d;
  logic             r_lv_d;
  logic [X_W-1:0]   r_x;
  logic [X_W-1:0]   r_y;
  logic [X_W-1:0]   r_wx;
  logic [X_W-1:0]   r_wy;

  logic             w_fv_rise;
  logic             w_fv_fall;
  logic             w_lv_fall;
  logic             w_clear;
  logic             w_pix_acc;
  logic [SUM_W-1:0] w_sum;
`ifdef CAM_BLUE_PEAK_EN
  logic [PIX_W-1:0] w_peak;
`endif

  assign w_fv_rise = frame_valid & ~r_fv_d;
  assign w_fv_fall = ~frame_valid & r_fv_d;
  assign w_lv_fall = ~line_valid & r_lv_d;
  assign w_clear   = (r_state == ST_IDLE) & w_fv_rise;
  assign w_pix_acc = (r_state == ST_ACTIVE) & ~w_fv_fall & pix_valid & line_valid & frame_valid;

  cam_window_acc #(
    .X_W        (X_W),
    .WIN_LOG2_W (WIN_LOG2_W),
    .WIN_LOG2_H (WIN_LOG2_H),
    .SUM_W      (SUM_W)
  ) u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .i_pix_en (w_pix_acc),
    .i_x      (r_x),
    .i_y      (r_y),
    .i_wx     (r_wx),
    .i_wy     (r_wy),
    .i_pix    (pix_blue),
    .o_sum    (w_sum)
`ifdef CAM_BLUE_PEAK_EN
    ,.o_peak  (w_peak)
`endif
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_ARM;
      r_fv_d    <= 1'b0;
      r_lv_d    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_wx      <= '0;
      r_wy      <= '0;
      blue_avg  <= '0;
      avg_valid <= 1'b0;
`ifdef CAM_BLUE_PEAK_EN
      blue_peak <= '0;
`endif
    end else begin
      r_fv_d    <= frame_valid;
      r_lv_d    <= line_valid;
      avg_valid <= 1'b0;
      case (r_state)
        // Never start mid-frame: wait for a blanking gap first.
        ST_ARM: begin
          if (!frame_valid) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_fv_rise) begin
            r_state <= ST_ACTIVE;
            r_x     <= '0;
            r_y     <= '0;
            r_wx    <= win_x;
            r_wy    <= win_y;
          end
        end
        ST_ACTIVE: begin
          if (w_fv_fall) begin
            blue_avg  <= w_sum[SUM_W-1 -: PIX_W];
            avg_valid <= 1'b1;
`ifdef CAM_BLUE_PEAK_EN
            blue_peak <= w_peak;
`endif
            r_state   <= ST_IDLE;
          end else begin
            if (w_pix_acc && (r_x != '1)) r_x <= r_x + 1'b1;
            if (w_lv_fall) begin
              r_x <= '0;
              if (r_y != '1) r_y <= r_y + 1'b1;
            end
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_camera_blue_window_avg.sv
// ----------------------------------------------------------------------------
// tb_camera_blue_window_avg : table-driven and randomized frame checks.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_camera_blue_window_avg;

  localparam int X_W   = 12;
  localparam int WL_W  = 2;
  localparam int WL_H  = 2;
  localparam int WIN_W = 1 << WL_W;
  localparam int WIN_H = 1 << WL_H;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           frame_valid;
  logic           line_valid;
  logic           pix_valid;
  logic [7:0]     pix_blue;
  logic [X_W-1:0] win_x;
  logic [X_W-1:0] win_y;
  logic [7:0]     blue_avg;
  logic           avg_valid;
`ifdef CAM_BLUE_PEAK_EN
  logic [7:0]     blue_peak;
`endif

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic prev_av = 1'b0;
  int pixmem [16][16];

  always #5 clk = ~clk;

  camera_blue_window_avg #(
    .X_W        (X_W),
    .WIN_LOG2_W (WL_W),
    .WIN_LOG2_H (WL_H)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pix_valid   (pix_valid),
    .pix_blue    (pix_blue),
    .win_x       (win_x),
    .win_y       (win_y),
    .blue_avg    (blue_avg),
    .avg_valid   (avg_valid)
`ifdef CAM_BLUE_PEAK_EN
    ,.blue_peak  (blue_peak)
`endif
  );

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (avg_valid === 1'b1) begin
      pulses++;
      check("avg_valid_single_cycle", int'(prev_av), 0);
    end
    prev_av = avg_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void fill_pix(int mode, int val);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (mode)
          0: pixmem[r][c] = val;
          1: pixmem[r][c] = c * 10 + r;
          2: pixmem[r][c] = 10;
          default: pixmem[r][c] = int'($urandom_range(0, 255));
        endcase
    if (mode == 2) begin
      pixmem[3][3] = 250;
      pixmem[7][7] = 255;
    end
  endfunction

  function automatic int model_avg(int cols, int rows, int wx, int wy);
    int s = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (c >= wx && c < wx + WIN_W && r >= wy && r < wy + WIN_H) s += pixmem[r][c];
    return s / (WIN_W * WIN_H);
  endfunction

  function automatic int model_peak(int cols, int rows, int wx, int wy);
    int m = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (c >= wx && c < wx + WIN_W && r >= wy && r < wy + WIN_H && pixmem[r][c] > m)
          m = pixmem[r][c];
    return m;
  endfunction

  task automatic start_frame(int wx, int wy);
    win_x = X_W'(wx);
    win_y = X_W'(wy);
    frame_valid = 1'b1;
    tick();
    tick();
    win_x = X_W'($urandom);
    win_y = X_W'($urandom);
  endtask

  task automatic drive_lines(int cols, int rows, bit junk, bit simfall, bit stalls);
    for (int r = 0; r < rows; r++) begin
      line_valid = 1'b1;
      for (int c = 0; c < cols; c++) begin
        if (stalls) begin
          repeat ($urandom_range(0, 2)) begin
            pix_valid = 1'b0;
            pix_blue  = 8'($urandom);
            tick();
          end
        end
        pix_valid = 1'b1;
        pix_blue  = 8'(pixmem[r][c]);
        tick();
      end
      pix_valid = 1'b0;
      line_valid = 1'b0;
      if (simfall && r == rows - 1) begin
        frame_valid = 1'b0;
        tick();
      end else begin
        tick();
        pix_valid = junk;
        pix_blue  = 8'd255;
        tick();
        pix_valid = 1'b0;
        tick();
      end
    end
  endtask

  task automatic end_frame();
    frame_valid = 1'b0;
    line_valid  = 1'b0;
    pix_valid   = 1'b0;
    repeat (3) tick();
  endtask

  task automatic expect_result(string name, int p0, int exp_avg, int exp_peak);
    int n = 0;
    while (pulses == p0 && n < 30) begin
      tick();
      n++;
    end
    check({name, "_pulses"}, pulses - p0, 1);
    check({name, "_avg"}, int'(blue_avg), exp_avg);
`ifdef CAM_BLUE_PEAK_EN
    check({name, "_peak"}, int'(blue_peak), exp_peak);
`else
    if (exp_peak < 0) check({name, "_peak_arg"}, exp_peak, 0);
`endif
    repeat (4) tick();
    check({name, "_hold"}, int'(blue_avg), exp_avg);
    check({name, "_no_extra_pulse"}, pulses - p0, 1);
  endtask

  typedef struct {
    int cols, rows, wx, wy, mode, val;
    bit junk, simfall;
    int exp_avg, exp_peak;
  } vec_t;

  initial begin
    vec_t vecs [$];
    int p0;

    vecs.push_back('{8, 8, 2, 2, 0, 100, 1'b0, 1'b0, 100, 100});
    vecs.push_back('{8, 8, 0, 0, 1, 0,   1'b0, 1'b0, 16,  33});
    vecs.push_back('{4, 4, 2, 2, 0, 200, 1'b0, 1'b0, 50,  200});
    vecs.push_back('{8, 8, 1, 1, 0, 10,  1'b1, 1'b0, 10,  10});
    vecs.push_back('{8, 8, 6, 0, 0, 64,  1'b0, 1'b0, 32,  64});
    vecs.push_back('{8, 8, 4, 4, 0, 77,  1'b0, 1'b1, 77,  77});
    vecs.push_back('{8, 8, 2, 2, 2, 0,   1'b0, 1'b0, 25,  250});

    // Reset held while a frame is already in progress.
    reset_n = 1'b0;
    frame_valid = 1'b1;
    line_valid = 1'b0;
    pix_valid = 1'b0;
    pix_blue = 8'd0;
    win_x = '0;
    win_y = '0;
    repeat (3) tick();
    check("reset_avg", int'(blue_avg), 0);
    check("reset_valid", int'(avg_valid), 0);
`ifdef CAM_BLUE_PEAK_EN
    check("reset_peak", int'(blue_peak), 0);
`endif
    reset_n = 1'b1;
    tick();
    fill_pix(0, 100);
    drive_lines(8, 8, 1'b0, 1'b0, 1'b0);
    end_frame();
    repeat (10) tick();
    check("partial_frame_no_pulse", pulses, 0);
    check("partial_frame_avg", int'(blue_avg), 0);

    p0 = pulses;
    start_frame(0, 0);
    drive_lines(8, 8, 1'b0, 1'b0, 1'b0);
    end_frame();
    expect_result("first_full_frame", p0, 100, 100);

    foreach (vecs[i]) begin
      fill_pix(vecs[i].mode, vecs[i].val);
      p0 = pulses;
      start_frame(vecs[i].wx, vecs[i].wy);
      drive_lines(vecs[i].cols, vecs[i].rows, vecs[i].junk, vecs[i].simfall, 1'b0);
      end_frame();
      expect_result($sformatf("vec%0d", i), p0, vecs[i].exp_avg, vecs[i].exp_peak);
    end

    // Asynchronous reset in the middle of a frame discards it.
    fill_pix(0, 90);
    start_frame(0, 0);
    drive_lines(8, 3, 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_avg", int'(blue_avg), 0);
    check("async_reset_valid", int'(avg_valid), 0);
    tick();
    reset_n = 1'b1;
    p0 = pulses;
    drive_lines(8, 3, 1'b0, 1'b0, 1'b0);
    end_frame();
    repeat (10) tick();
    check("async_reset_no_pulse", pulses - p0, 0);
    check("async_reset_avg_after", int'(blue_avg), 0);

    for (int k = 0; k < 10; k++) begin
      int cols, rows, wx, wy;
      bit junk, simfall;
      cols = int'($urandom_range(1, 16));
      rows = int'($urandom_range(1, 16));
      wx   = int'($urandom_range(0, 17));
      wy   = int'($urandom_range(0, 17));
      junk = 1'($urandom);
      simfall = 1'($urandom);
      fill_pix(3, 0);
      p0 = pulses;
      start_frame(wx, wy);
      drive_lines(cols, rows, junk, simfall, 1'b1);
      end_frame();
      expect_result($sformatf("rand%0d", k), p0,
                    model_avg(cols, rows, wx, wy), model_peak(cols, rows, wx, wy));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
